spi_master: RTL and testbench

- Mode-0 SPI master shift engine (CPOL=0, CPHA=0), MSB first, single chip select.
- Upstream logic loads a word with a start/busy/done handshake. The block serialises it on mosi and captures miso into rx_data.
- It is the stage that drives the external SPI slave bus, and it consumes the gate-level data path that produces tx_data.

---
 rtl/spi_master_if.sv | 25 ++
 rtl/spi_master.sv | 146 ++++++++++++++
 tb/tb_spi_master.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_if.sv
// rtl/spi_master_if.sv - handshake and SPI bus signals for spi_master
// master: the shift engine's view; slave: the upstream driver plus external SPI device.
interface spi_master_if #(
  parameter int DATA_W = 8
) ();
  logic              start;
  logic [DATA_W-1:0] tx_data;
  logic [DATA_W-1:0] rx_data;
  logic              busy;
  logic              done;
  logic              sclk;
  logic              mosi;
  logic              miso;
  logic              cs_n;

  modport master (
    input  start, tx_data, miso,
    output rx_data, busy, done, sclk, mosi, cs_n
  );

  modport slave (
    output start, tx_data, miso,
    input  rx_data, busy, done, sclk, mosi, cs_n
  );
endinterface

// File: rtl/spi_master.sv
// rtl/spi_master.sv - mode-0 SPI master shift engine, MSB first, single chip select
// All outputs are registered; a transfer is IDLE -> SETUP -> (HIGH <-> LOW) x DATA_W -> HOLD -> IDLE.
module spi_master #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4
) (
  input logic          clk,
  input logic          rst,
  spi_master_if.master bus
);
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(DATA_W);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    HOLD
  } state_e;

  state_e            state_q,   state_d;
  logic [DW-1:0]     div_q,     div_d;
  logic [BW-1:0]     bit_q,     bit_d;
  logic [DATA_W-1:0] tx_sr_q,   tx_sr_d;
  logic [DATA_W-1:0] rx_sr_q,   rx_sr_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              busy_q,    busy_d;
  logic              done_q,    done_d;
  logic              sclk_q,    sclk_d;
  logic              mosi_q,    mosi_d;
  logic              cs_n_q,    cs_n_d;
  logic              tick;

  // SETUP is entered on the accepting edge itself, so it runs one cycle longer
  // than a normal phase; that keeps the first rise at edge 1+CLK_DIV.
  always_comb begin
    tick = 1'b0;
    if (state_q == SETUP) begin
      tick = (div_q == DW'(CLK_DIV));
    end else begin
      tick = (div_q == DW'(CLK_DIV - 1));
    end
  end

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bit_d     = bit_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    rx_data_d = rx_data_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    cs_n_d    = cs_n_q;

    if (state_q != IDLE) begin
      div_d = tick ? '0 : div_q + DW'(1);
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = SETUP;
          cs_n_d  = 1'b0;
          busy_d  = 1'b1;
          tx_sr_d = bus.tx_data;
          mosi_d  = bus.tx_data[DATA_W-1];
          rx_sr_d = '0;
          div_d   = '0;
          bit_d   = '0;
        end
      end
      SETUP, LOW: begin
        if (tick) begin
          state_d = HIGH;
          sclk_d  = 1'b1;
          rx_sr_d = {rx_sr_q[DATA_W-2:0], bus.miso};
        end
      end
      HIGH: begin
        if (tick) begin
          sclk_d = 1'b0;
          if (bit_q == BW'(DATA_W - 1)) begin
            state_d = HOLD;
          end else begin
            state_d = LOW;
            bit_d   = bit_q + BW'(1);
            tx_sr_d = {tx_sr_q[DATA_W-2:0], 1'b0};
            mosi_d  = tx_sr_q[DATA_W-2];
          end
        end
      end
      HOLD: begin
        if (tick) begin
          state_d   = IDLE;
          cs_n_d    = 1'b1;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          rx_data_d = rx_sr_q;
          mosi_d    = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      div_q     <= '0;
      bit_q     <= '0;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      rx_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      cs_n_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      rx_data_q <= rx_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      cs_n_q    <= cs_n_d;
    end
  end

  assign bus.rx_data = rx_data_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.sclk    = sclk_q;
  assign bus.mosi    = mosi_q;
  assign bus.cs_n    = cs_n_q;
endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - scoreboard bench for spi_master at CLK_DIV=4 and CLK_DIV=1
module tb_spi_master;
  localparam int W    = 8;
  localparam int D0   = 4;
  localparam int D1   = 1;
  localparam int LAT0 = 1 + (2 * W + 1) * D0;
  localparam int LAT1 = 1 + (2 * W + 1) * D1;

  typedef struct {
    logic [W-1:0] tx;
    logic [W-1:0] rx;
    int           e0;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_master_if #(.DATA_W(W)) if0 ();
  spi_master_if #(.DATA_W(W)) if1 ();

  spi_master #(.DATA_W(W), .CLK_DIV(D0)) dut0 (.clk(clk), .rst(rst), .bus(if0.master));
  spi_master #(.DATA_W(W), .CLK_DIV(D1)) dut1 (.clk(clk), .rst(rst), .bus(if1.master));

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t q0[$];
  exp_t q1[$];

  logic         loop0 = 1'b1;
  logic [W-1:0] sw0   = '0;
  logic         gap_check = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // External slave: loopback, or shifts sw0 out MSB first, advancing after each sclk fall.
  int   fcnt   = 0;
  logic prev_s = 1'b0;
  always @(negedge clk) begin
    if (if0.cs_n) begin
      fcnt = 0;
    end else if (prev_s && !if0.sclk) begin
      fcnt++;
    end
    prev_s = if0.sclk;
    if (loop0) if0.miso = if0.mosi;
    else if0.miso = (fcnt < W) ? sw0[W-1-fcnt] : 1'b0;
    if1.miso = if1.mosi;
  end

  // Monitor for the CLK_DIV=4 instance.
  logic         prev_sclk = 1'b0;
  int           phase = 0;
  int           rises = 0;
  int           cs_hi = 0;
  logic [W-1:0] mosi_bits = '0;
  logic [W-1:0] last_rx = '0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_sclk = 1'b0;
      phase     = 0;
      rises     = 0;
      cs_hi     = 0;
      mosi_bits = '0;
      last_rx   = '0;
    end else begin
      phase++;
      if (if0.sclk && !prev_sclk) begin
        if (rises > 0) chk("low_phase_len", phase, D0);
        mosi_bits = {mosi_bits[W-2:0], if0.mosi};
        rises++;
        phase = 0;
      end else if (!if0.sclk && prev_sclk) begin
        chk("high_phase_len", phase, D0);
        phase = 0;
      end
      prev_sclk = if0.sclk;
      if (!if0.cs_n && cs_hi > 0) begin
        chk("rx_data_held", if0.rx_data, last_rx);
        if (gap_check) begin
          chk("cs_n_gap", cs_hi, 1);
          gap_check = 1'b0;
        end
      end
      if (if0.cs_n) cs_hi++;
      else cs_hi = 0;
      if (if0.done) begin
        if (q0.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done0 actual=1 required=0 (cycle %0d)", cyc);
        end else begin
          e = q0.pop_front();
          chk("rx_data0", if0.rx_data, e.rx);
          chk("done_latency0", cyc - e.e0, LAT0);
          chk("mosi_at_rises", mosi_bits, e.tx);
          chk("sclk_pulses", rises, W);
        end
        last_rx   = if0.rx_data;
        rises     = 0;
        mosi_bits = '0;
      end
    end
  end

  // Monitor for the CLK_DIV=1 instance.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && if1.done) begin
      if (q1.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done1 actual=1 required=0 (cycle %0d)", cyc);
      end else begin
        e = q1.pop_front();
        chk("rx_data1", if1.rx_data, e.rx);
        chk("done_latency1", cyc - e.e0, LAT1);
      end
    end
  end

  task automatic wait_done0();
    int n = 0;
    while (!if0.done && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!if0.done) begin
      checks++;
      failures++;
      $display("FAIL done0_timeout actual=0 required=1 (cycle %0d)", cyc);
    end
  endtask

  task automatic start0(input logic [W-1:0] tx, input logic loop, input logic [W-1:0] sw, output int e0);
    @(negedge clk);
    if0.tx_data = tx;
    loop0 = loop;
    sw0   = sw;
    if0.start = 1'b1;
    @(posedge clk);
    #1;
    e0 = cyc;
    q0.push_back('{tx, loop ? tx : sw, cyc});
  endtask

  task automatic run0(input logic [W-1:0] tx, input logic loop, input logic [W-1:0] sw);
    int e0;
    start0(tx, loop, sw, e0);
    @(negedge clk);
    if0.start = 1'b0;
    wait_done0();
    @(negedge clk);
  endtask

  task automatic run1(input logic [W-1:0] tx);
    int n = 0;
    @(negedge clk);
    if1.tx_data = tx;
    if1.start = 1'b1;
    @(posedge clk);
    #1;
    q1.push_back('{tx, tx, cyc});
    @(negedge clk);
    if1.start = 1'b0;
    while (!if1.done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!if1.done) begin
      checks++;
      failures++;
      $display("FAIL done1_timeout actual=0 required=1 (cycle %0d)", cyc);
    end
    @(negedge clk);
  endtask

  initial begin
    int e0;
    int e0b;
    if0.start = 1'b1;
    if0.tx_data = 8'hA5;
    if0.miso = 1'b0;
    if1.start = 1'b0;
    if1.tx_data = '0;
    if1.miso = 1'b0;

    // Reset held with start asserted.
    repeat (3) begin
      @(negedge clk);
      chk("rst_sclk", if0.sclk, 1'b0);
      chk("rst_cs_n", if0.cs_n, 1'b1);
      chk("rst_busy", if0.busy, 1'b0);
      chk("rst_done", if0.done, 1'b0);
      chk("rst_rx_data", if0.rx_data, '0);
    end
    if0.start = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run0(8'hA5, 1'b1, '0);
    run1(8'hA5);
    run1(W'($urandom));
    run0(8'hFF, 1'b0, 8'h3C);

    // start pulsed mid-transfer with a different word must be ignored.
    start0(8'hC3, 1'b1, '0, e0);
    @(negedge clk);
    if0.start = 1'b0;
    repeat (18) @(negedge clk);
    if0.tx_data = 8'h00;
    if0.start = 1'b1;
    @(negedge clk);
    if0.start = 1'b0;
    while (cyc < e0 + LAT0 - 1) @(negedge clk);
    chk("busy_before_done", if0.busy, 1'b1);
    @(negedge clk);
    chk("busy_at_done", if0.busy, 1'b0);
    chk("done_at_edge_69", if0.done, 1'b1);
    repeat (4) @(negedge clk);

    // Back-to-back with start held high.
    start0(8'h12, 1'b1, '0, e0);
    @(negedge clk);
    if0.tx_data = 8'h34;
    @(negedge clk);
    gap_check = 1'b1;
    wait_done0();
    @(posedge clk);
    #1;
    e0b = cyc;
    q0.push_back('{8'h34, 8'h34, cyc});
    chk("b2b_second_accept", e0b - e0, LAT0 + 1);
    @(negedge clk);
    if0.start = 1'b0;
    wait_done0();
    @(negedge clk);
    chk("b2b_gap_seen", gap_check, 1'b0);

    // Reset asserted on the 4th sclk rise.
    start0(8'hF0, 1'b1, '0, e0);
    @(negedge clk);
    if0.start = 1'b0;
    while (cyc < e0 + 1 + 7 * D0 - 1) @(negedge clk);
    rst = 1'b1;
    void'(q0.pop_back());
    @(negedge clk);
    rst = 1'b0;
    chk("abort_cs_n", if0.cs_n, 1'b1);
    chk("abort_sclk", if0.sclk, 1'b0);
    chk("abort_busy", if0.busy, 1'b0);
    chk("abort_rx_data", if0.rx_data, '0);
    chk("abort_done", if0.done, 1'b0);
    repeat (LAT0) @(negedge clk);
    run0(8'h5A, 1'b1, '0);

    // Randomised traffic mixing loopback and slave-driven miso.
    for (int i = 0; i < 8; i++) begin
      run0(W'($urandom), 1'($urandom), W'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    for (int i = 0; i < 3; i++) run1(W'($urandom));

    repeat (5) @(negedge clk);
    chk("scoreboard0_empty", q0.size(), 0);
    chk("scoreboard1_empty", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
